main_memory_responder: RTL and testbench

Memory-side responder for the direct-mapped data cache controller. Accepts single-word write-through requests (`write_mem`) and block refill requests (`read_mem`). Models a fixed access latency with a counter, then returns a one-cycle `ready` pulse, plus the 4-word block for reads. Sits between the cache controller and the backing 1024×32 word store in the single-cycle RISC-V core.

---
 rtl/main_memory_responder_pkg.sv | 24 ++
 rtl/main_memory_responder_if.sv | 26 ++
 rtl/main_memory_responder_mem_array.sv | 37 +++
 rtl/main_memory_responder.sv | 90 +++++++++
 tb/tb_main_memory_responder.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/main_memory_responder_pkg.sv
// Shared types and address-field layout for the main memory responder and its
// cache controller.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned WORD_W          = 32;

    // Word-address field slices, shared with the cache controller
    localparam int unsigned TAG_MSB    = 9;
    localparam int unsigned TAG_LSB    = 7;
    localparam int unsigned INDEX_MSB  = 6;
    localparam int unsigned INDEX_LSB  = 2;
    localparam int unsigned OFFSET_MSB = 1;
    localparam int unsigned OFFSET_LSB = 0;
    localparam int unsigned OFFSET_W   = OFFSET_MSB - OFFSET_LSB + 1;

endpackage

// File: rtl/main_memory_responder_if.sv
// Request/response bus between the cache controller (master) and the memory
// responder (slave).
interface main_memory_responder_if #(
    parameter int unsigned ADDR_W = 10
);
    import mem_pkg::*;

    logic                 read_mem;
    logic                 write_mem;
    logic [ADDR_W-1:0]    addr;
    logic [WORD_W-1:0]    wdata;
    logic                 ready;
    logic [BLOCK_W-1:0]   rdata_block;
    logic                 busy;

    modport master (
        output read_mem, write_mem, addr, wdata,
        input  ready, rdata_block, busy
    );

    modport slave (
        input  read_mem, write_mem, addr, wdata,
        output ready, rdata_block, busy
    );

endinterface

// File: rtl/main_memory_responder_mem_array.sv
// Word store with one single-word write port and one aligned 4-word read port,
// both registered on posedge. Contents are never cleared by reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [WORD_W-1:0]            wdata,
    input  logic                         re,
    input  logic [ADDR_W-OFFSET_W-1:0]   rblk,
    output logic [BLOCK_W-1:0]           rdata_block
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Block-aligned read: the offset bits are rebuilt, so no index can leave the array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_block <= '0;
        end else if (re) begin
            for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++) begin
                rdata_block[i*WORD_W +: WORD_W] <= mem[{rblk, OFFSET_W'(i)}];
            end
        end
    end

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side responder: accepts one write-through or block-refill request,
// waits a fixed latency, then pulses ready for one cycle.
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned ACCESS_LATENCY = 4,
    parameter int unsigned ADDR_W         = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    main_memory_responder_if.slave  bus
);

    state_t              state;
    logic [3:0]          cnt;
    logic                op_write;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                ready_q;
    logic                busy_q;
    logic                last_cycle;
    logic                mem_we;
    logic                mem_re;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.write_mem || bus.read_mem) begin
                        op_write <= bus.write_mem;
                        addr_q   <= bus.addr;
                        wdata_q  <= bus.wdata;
                        cnt      <= 4'(ACCESS_LATENCY - 1);
                        busy_q   <= 1'b1;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        ready_q <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory ports fire on the BUSY->DONE edge, so data lands as ready rises;
    // async reset drops state to IDLE, which also cancels a pending write.
    assign last_cycle = (state == ST_BUSY) && (cnt == '0);
    assign mem_we     = last_cycle && op_write;
    assign mem_re     = last_cycle && !op_write;

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (mem_we),
        .waddr       (addr_q),
        .wdata       (wdata_q),
        .re          (mem_re),
        .rblk        (addr_q[ADDR_W-1:OFFSET_W]),
        .rdata_block (bus.rdata_block)
    );

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder at ACCESS_LATENCY 4 and 1.
module tb_main_memory_responder;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    main_memory_responder_if #(.ADDR_W(10)) b4 ();
    main_memory_responder_if #(.ADDR_W(10)) b1 ();

    main_memory_responder #(
        .ACCESS_LATENCY (4),
        .ADDR_W         (10)
    ) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    main_memory_responder #(
        .ACCESS_LATENCY (1),
        .ADDR_W         (10)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request on the latency-4 responder; addr/wdata are scrambled after
    // acceptance, and with hold=0 the request drops after one cycle.
    task automatic txn4(input logic wr, input logic rd, input logic [9:0] a,
                        input logic [31:0] d, input logic hold,
                        input logic [127:0] exp_blk, input logic [127:0] mask,
                        input string tag);
        @(negedge clk);
        b4.write_mem = wr;
        b4.read_mem  = rd;
        b4.addr      = a;
        b4.wdata     = d;
        @(posedge clk); #1;
        check({tag, "_busy_accept"}, 128'(b4.busy), 128'(1'b1));
        @(negedge clk);
        b4.addr  = ~a;
        b4.wdata = ~d;
        if (!hold) begin
            b4.write_mem = 1'b0;
            b4.read_mem  = 1'b0;
        end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check({tag, "_ready"}, 128'(b4.ready), 128'(k == 4));
            if (k == 4 && mask != '0)
                check({tag, "_rdata"}, b4.rdata_block & mask, exp_blk & mask);
        end
        @(negedge clk);
        b4.write_mem = 1'b0;
        b4.read_mem  = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ready_fall"}, 128'(b4.ready), 128'(1'b0));
        check({tag, "_busy_end"}, 128'(b4.busy), 128'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] w0;
        logic [127:0] w1;
        total = 0;
        bad   = 0;
        w0 = 128'hFFFF_FFFF;
        w1 = 128'hFFFF_FFFF << 32;
        rst_n = 1'b0;
        b4.read_mem = 1'b0; b4.write_mem = 1'b0; b4.addr = '0; b4.wdata = '0;
        b1.read_mem = 1'b0; b1.write_mem = 1'b0; b1.addr = '0; b1.wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 128'(b4.ready), 128'(1'b0));
        check("rst_busy", 128'(b4.busy), 128'(1'b0));
        check("rst_rdata", b4.rdata_block, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then refill of the same block
        txn4(1'b1, 1'b0, 10'h005, 32'h1234_5678, 1'b1, '0, '0, "wr05");
        txn4(1'b0, 1'b1, 10'h007, 32'h0, 1'b1, 128'h1234_5678 << 32, w1, "rd07");
        check("rd07_hold", b4.rdata_block & w1, (128'h1234_5678 << 32));

        // Reset mid-BUSY discards the write
        txn4(1'b1, 1'b0, 10'h080, 32'h1111_1111, 1'b1, '0, '0, "wr80");
        @(negedge clk);
        b4.write_mem = 1'b1; b4.addr = 10'h080; b4.wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("abort_busy_accept", 128'(b4.busy), 128'(1'b1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy_now", 128'(b4.busy), 128'(1'b0));
        check("abort_ready_now", 128'(b4.ready), 128'(1'b0));
        @(negedge clk);
        b4.write_mem = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("abort_no_ready", 128'(b4.ready), 128'(1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        txn4(1'b0, 1'b1, 10'h080, 32'h0, 1'b1, 128'h1111_1111, w0, "rd80");

        // Simultaneous read+write behaves as a write
        txn4(1'b1, 1'b1, 10'h3FC, 32'hA5A5_A5A5, 1'b1, '0, '0, "both");
        check("both_rdata_kept", b4.rdata_block & w0, 128'h1111_1111);
        txn4(1'b0, 1'b1, 10'h3FC, 32'h0, 1'b1, 128'hA5A5_A5A5, w0, "rd3fc");

        // Fill the top block, then read it with a one-cycle request and at the last word
        txn4(1'b1, 1'b0, 10'h3FD, 32'h0000_3FDD, 1'b1, '0, '0, "wr3fd");
        txn4(1'b1, 1'b0, 10'h3FE, 32'h0000_3FEE, 1'b1, '0, '0, "wr3fe");
        txn4(1'b1, 1'b0, 10'h3FF, 32'hCAFE_F00D, 1'b1, '0, '0, "wr3ff");
        txn4(1'b0, 1'b1, 10'h3FE, 32'h0, 1'b0,
             128'hCAFE_F00D_0000_3FEE_0000_3FDD_A5A5_A5A5, '1, "drop");
        txn4(1'b0, 1'b1, 10'h3FF, 32'h0, 1'b1,
             128'hCAFE_F00D_0000_3FEE_0000_3FDD_A5A5_A5A5, '1, "wrap");

        // Latency 1 with the request held: DONE never accepts, so period is 3
        @(negedge clk);
        b1.write_mem = 1'b1; b1.addr = 10'h010; b1.wdata = 32'h0000_0077;
        for (int p = 0; p < 9; p++) begin
            @(posedge clk); #1;
            check("b2b_ready", 128'(b1.ready), 128'((p % 3) == 1));
            check("b2b_busy", 128'(b1.busy), 128'((p % 3) != 2));
        end
        @(negedge clk);
        b1.write_mem = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle", 128'(b1.busy), 128'(1'b0));
        @(negedge clk);
        b1.read_mem = 1'b1;
        @(posedge clk); #1;
        check("l1_rd_ready0", 128'(b1.ready), 128'(1'b0));
        @(posedge clk); #1;
        check("l1_rd_ready1", 128'(b1.ready), 128'(1'b1));
        check("l1_rd_data", b1.rdata_block & w0, 128'h77);
        @(negedge clk);
        b1.read_mem = 1'b0;
        @(posedge clk); #1;
        check("l1_rd_fall", 128'(b1.ready), 128'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
